// File: rtl/freq_sort_pkg.sv
// Shared constants, FSM encoding and entry type for the frequency sorter.
// The sort key puts zero-frequency symbols last and breaks frequency ties by symbol index.
package freq_sort_pkg;

    localparam int NSYM = 16;
    localparam int SW   = 4;
    localparam int CW   = 9;
    localparam int KW   = 1 + CW + SW;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SORT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef struct packed {
        logic [SW-1:0] sym;
        logic [CW-1:0] freq;
    } entry_t;

    // Unique per entry, so the final order never depends on the initial arrangement.
    function automatic logic [KW-1:0] sort_key(input entry_t e);
        return {(e.freq == '0), e.freq, e.sym};
    endfunction

endpackage

// File: rtl/freq_sort_if.sv
// Bundle between the symbol counter / tree builder side and the sorter.
// count_over is a level valid for FREQ_IN; sort_over is a level valid for the SORTED_* outputs.
interface freq_sort_if;
    import freq_sort_pkg::*;

    logic                 count_over;
    logic [NSYM*CW-1:0]   FREQ_IN;
    logic [NSYM*SW-1:0]   SORTED_SYM;
    logic [NSYM*CW-1:0]   SORTED_FREQ;
    logic [SW:0]          NZ_COUNT;
    logic                 sort_over;
    logic [1:0]           dbg_state;

    modport master (
        output count_over, FREQ_IN,
        input  SORTED_SYM, SORTED_FREQ, NZ_COUNT, sort_over, dbg_state
    );

    modport slave (
        input  count_over, FREQ_IN,
        output SORTED_SYM, SORTED_FREQ, NZ_COUNT, sort_over, dbg_state
    );

endinterface

// File: rtl/freq_sort_cmp_swap.sv
// Combinational compare-exchange: the entry with the lower sort key goes to lo_o.
module freq_sort_cmp_swap
    import freq_sort_pkg::*;
(
    input  entry_t a_i,
    input  entry_t b_i,
    output entry_t lo_o,
    output entry_t hi_o
);

    logic swap;

    assign swap = sort_key(b_i) < sort_key(a_i);
    assign lo_o = swap ? b_i : a_i;
    assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/freq_sort.sv
// Captures the frequency table on a rising count_over and runs NSYM odd-even
// transposition passes, one per clock, leaving entry 0 as the rarest symbol.
module freq_sort
    import freq_sort_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    freq_sort_if.slave  bus
);

    localparam logic [SW:0] LAST_PASS = (SW+1)'(NSYM-1);
    localparam logic [SW:0] ONE       = (SW+1)'(1);

    logic [1:0]  state_q, state_d;
    logic [SW:0] pass_q, pass_d;
    logic [SW:0] nz_q, nz_d;
    logic [SW:0] pop;
    logic        co_s_q, co_prev_q;
    logic        rise;

    entry_t ent_q    [NSYM];
    entry_t ent_d    [NSYM];
    entry_t even_res [NSYM];
    entry_t odd_res  [NSYM];

    // count_over is sampled once before edge detection, which sets the start-to-done latency.
    assign rise = co_s_q & ~co_prev_q;

    for (genvar g = 0; g < NSYM/2; g++) begin : g_even
        freq_sort_cmp_swap u_cs (
            .a_i  (ent_q[2*g]),
            .b_i  (ent_q[2*g+1]),
            .lo_o (even_res[2*g]),
            .hi_o (even_res[2*g+1])
        );
    end

    for (genvar g = 0; g < NSYM/2-1; g++) begin : g_odd
        freq_sort_cmp_swap u_cs (
            .a_i  (ent_q[2*g+1]),
            .b_i  (ent_q[2*g+2]),
            .lo_o (odd_res[2*g+1]),
            .hi_o (odd_res[2*g+2])
        );
    end

    // Odd passes leave the two end entries untouched.
    assign odd_res[0]      = ent_q[0];
    assign odd_res[NSYM-1] = ent_q[NSYM-1];

    always_comb begin
        pop = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (bus.FREQ_IN[i*CW +: CW] != '0) pop = pop + ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        nz_d    = nz_q;
        for (int i = 0; i < NSYM; i++) ent_d[i] = ent_q[i];

        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                for (int i = 0; i < NSYM; i++) begin
                    ent_d[i].sym  = SW'(i);
                    ent_d[i].freq = bus.FREQ_IN[i*CW +: CW];
                end
                nz_d    = pop;
                pass_d  = '0;
                state_d = ST_SORT;
            end
            ST_SORT: begin
                for (int i = 0; i < NSYM; i++) begin
                    ent_d[i] = pass_q[0] ? odd_res[i] : even_res[i];
                end
                pass_d = pass_q + ONE;
                if (pass_q == LAST_PASS) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!bus.count_over) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= ST_IDLE;
            pass_q    <= '0;
            nz_q      <= '0;
            co_s_q    <= 1'b0;
            co_prev_q <= 1'b0;
            for (int i = 0; i < NSYM; i++) ent_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            nz_q      <= nz_d;
            co_s_q    <= bus.count_over;
            co_prev_q <= co_s_q;
            for (int i = 0; i < NSYM; i++) ent_q[i] <= ent_d[i];
        end
    end

    always_comb begin
        bus.SORTED_SYM  = '0;
        bus.SORTED_FREQ = '0;
        for (int k = 0; k < NSYM; k++) begin
            bus.SORTED_SYM[k*SW +: SW]  = ent_q[k].sym;
            bus.SORTED_FREQ[k*CW +: CW] = ent_q[k].freq;
        end
    end

    assign bus.NZ_COUNT  = nz_q;
    assign bus.sort_over = (state_q == ST_DONE);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_freq_sort.sv
// Random and directed sorts of the frequency table, checked against a selection-sort reference.
module tb_freq_sort;
    import freq_sort_pkg::*;

    localparam int W = (SW + 1) + NSYM*SW + NSYM*CW;

    logic clk;
    logic nrst;
    int   err_cnt = 0;
    int   chk_cnt = 0;
    logic [W-1:0] exp_q [$];

    freq_sort_if bus ();

    freq_sort dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] model(input logic [NSYM*CW-1:0] f);
        logic [CW-1:0]      fr [NSYM];
        bit                 used [NSYM];
        logic [NSYM*SW-1:0] s;
        logic [NSYM*CW-1:0] q;
        int k, nz, best;
        k = 0;
        nz = 0;
        s = '0;
        q = '0;
        for (int i = 0; i < NSYM; i++) begin
            fr[i] = f[i*CW +: CW];
            used[i] = 1'b0;
            if (fr[i] != 0) nz++;
        end
        // Rarest nonzero first; strict < keeps the lowest index on ties.
        repeat (nz) begin
            best = -1;
            for (int i = 0; i < NSYM; i++) begin
                if (!used[i] && fr[i] != 0 && (best < 0 || fr[i] < fr[best])) best = i;
            end
            used[best] = 1'b1;
            s[k*SW +: SW] = SW'(best);
            q[k*CW +: CW] = fr[best];
            k++;
        end
        for (int i = 0; i < NSYM; i++) begin
            if (fr[i] == 0) begin
                s[k*SW +: SW] = SW'(i);
                q[k*CW +: CW] = '0;
                k++;
            end
        end
        return {(SW+1)'(nz), s, q};
    endfunction

    function automatic logic [W-1:0] dut_out();
        return {bus.NZ_COUNT, bus.SORTED_SYM, bus.SORTED_FREQ};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rising sort_over must match the oldest outstanding expectation.
    initial begin
        logic so_prev;
        so_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.sort_over === 1'b1 && so_prev !== 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_sort_over", W'(1), W'(0));
                else chk("sorted_result", dut_out(), exp_q.pop_front());
            end
            so_prev = bus.sort_over;
        end
    end

    task automatic start_run(input logic [NSYM*CW-1:0] f);
        @(negedge clk);
        bus.FREQ_IN = f;
        exp_q.push_back(model(f));
        bus.count_over = 1'b1;
    endtask

    task automatic wait_done(input int drop_at);
        int edges;
        bit got;
        edges = 0;
        got = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.sort_over === 1'b1) got = 1'b1;
            else if (edges == drop_at) bus.count_over = 1'b0;
        end
        if (!got) chk("sort_over_timeout", W'(0), W'(1));
        else chk("latency", W'(edges - 1), W'(NSYM + 2));
    endtask

    task automatic release_run();
        bus.count_over = 1'b0;
        @(posedge clk);
        #1;
        chk("sort_over_fall", W'(bus.sort_over), W'(0));
    endtask

    function automatic logic [NSYM*CW-1:0] rand_freq();
        logic [NSYM*CW-1:0] f;
        for (int i = 0; i < NSYM; i++) begin
            if ($urandom_range(0, 3) == 0) f[i*CW +: CW] = '0;
            else f[i*CW +: CW] = CW'($urandom_range(1, 256));
        end
        return f;
    endfunction

    initial begin
        logic [NSYM*CW-1:0] f;
        logic [W-1:0]       held;

        nrst = 1'b0;
        bus.count_over = 1'b0;
        bus.FREQ_IN = '0;
        #1;
        chk("reset_outputs", dut_out(), W'(0));
        chk("reset_sort_over", W'(bus.sort_over), W'(0));
        chk("reset_state", W'(bus.dbg_state), W'(ST_IDLE));
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        // Five nonzero symbols in descending frequency
        f = '0;
        f[1*CW +: CW] = CW'(8);
        f[2*CW +: CW] = CW'(7);
        f[3*CW +: CW] = CW'(5);
        f[4*CW +: CW] = CW'(4);
        f[5*CW +: CW] = CW'(2);
        start_run(f); wait_done(0); release_run();

        // Frequency ties resolved by symbol index
        f = '0;
        f[9*CW +: CW] = CW'(4);
        f[3*CW +: CW] = CW'(4);
        f[0*CW +: CW] = CW'(4);
        start_run(f); wait_done(0); release_run();

        f = '0;
        start_run(f); wait_done(0); release_run();

        f = '0;
        f[15*CW +: CW] = CW'(256);
        start_run(f); wait_done(0); release_run();

        for (int i = 0; i < NSYM; i++) f[i*CW +: CW] = CW'(16 - i);
        start_run(f); wait_done(0); release_run();

        // Abort mid-sort: nothing queued for this run
        @(negedge clk);
        bus.FREQ_IN = rand_freq();
        bus.count_over = 1'b1;
        repeat (9) @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        chk("abort_outputs", dut_out(), W'(0));
        chk("abort_sort_over", W'(bus.sort_over), W'(0));
        chk("abort_state", W'(bus.dbg_state), W'(ST_IDLE));
        f = rand_freq();
        bus.FREQ_IN = f;
        exp_q.push_back(model(f));
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        wait_done(0); release_run();

        // Hold count_over through DONE while the table changes
        f = rand_freq();
        held = model(f);
        start_run(f); wait_done(0);
        bus.FREQ_IN = rand_freq();
        repeat (5) @(posedge clk);
        #1;
        chk("hold_outputs", dut_out(), held);
        chk("hold_sort_over", W'(bus.sort_over), W'(1));
        chk("hold_state", W'(bus.dbg_state), W'(ST_DONE));
        release_run();
        repeat (25) @(posedge clk);
        #1;
        chk("no_restart", W'(bus.sort_over), W'(0));

        // count_over falls during SORT: one-cycle DONE
        start_run(rand_freq()); wait_done(10);
        @(posedge clk);
        #1;
        chk("short_done", W'(bus.sort_over), W'(0));

        for (int n = 0; n < 6; n++) begin
            start_run(rand_freq()); wait_done(0); release_run();
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", W'(exp_q.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
